// File: rtl/ecdsa_cmd_ctrl_pkg.sv
// ECDSA command controller shared types.
// Ops, response status, FSM states and FIFO entry layout.
package ecdsa_ctrl_pkg;

  localparam int TAG_MAX_W = 16;

  typedef enum logic [1:0] {
    OP_KEYGEN = 2'd0,
    OP_SIGN   = 2'd1,
    OP_VERIFY = 2'd2,
    OP_CLRKEY = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_FAIL    = 2'd1,
    ST_NOKEY   = 2'd2,
    ST_TIMEOUT = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  typedef struct packed {
    op_e                  op;
    logic [TAG_MAX_W-1:0] tag;
  } fifo_entry_t;

  function automatic logic needs_key(op_e op);
    return (op == OP_SIGN) || (op == OP_VERIFY);
  endfunction

endpackage

// File: rtl/ecdsa_cmd_ctrl_if.sv
// Host-side command and response channels.
// master = host, slave = controller.
interface ecdsa_cmd_ctrl_if
  import ecdsa_ctrl_pkg::*;
#(
  parameter int KEY_SIZE = 256,
  parameter int TAG_W    = 4
);

  logic                cmd_valid;
  logic                cmd_ready;
  op_e                 cmd_op;
  logic [TAG_W-1:0]    cmd_tag;

  logic                rsp_valid;
  logic                rsp_ready;
  op_e                 rsp_op;
  logic [TAG_W-1:0]    rsp_tag;
  status_e             rsp_status;
  logic [KEY_SIZE-1:0] rsp_r;
  logic [KEY_SIZE-1:0] rsp_s;

  modport master (
    output cmd_valid, cmd_op, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_op, rsp_tag,
    input  rsp_status, rsp_r, rsp_s
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_op, rsp_tag,
    output rsp_status, rsp_r, rsp_s
  );

endinterface

// File: rtl/ecdsa_cmd_ctrl_fifo.sv
// Command FIFO: DEPTH entries, registered occupancy.
// A pop never frees a slot for a push in the same cycle.
module ecdsa_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage write, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ecdsa_cmd_ctrl.sv
// ECDSA command controller: queues host ops, drives engines.
// Optional watchdog: define ECDSA_CMD_TIMEOUT_EN.
module ecdsa_cmd_ctrl
  import ecdsa_ctrl_pkg::*;
#(
  parameter int KEY_SIZE = 256,
  parameter int DEPTH    = 4,
  parameter int TAG_W    = 4,
  parameter int TMO_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  ecdsa_cmd_ctrl_if.slave     bus,
  output logic                ecc_go,
  input  logic                ecc_done,
  input  logic                ecc_infinity,
  input  logic [KEY_SIZE-1:0] ecc_qx,
  input  logic [KEY_SIZE-1:0] ecc_qy,
  output logic                sign_go,
  input  logic                sign_ready,
  input  logic                sign_done,
  input  logic                sign_failure,
  input  logic [KEY_SIZE-1:0] sign_r,
  input  logic [KEY_SIZE-1:0] sign_s,
  output logic                verify_go,
  input  logic                verify_ready,
  input  logic                verify_done,
  input  logic                verify_ok,
  output logic [KEY_SIZE-1:0] pub_qx,
  output logic [KEY_SIZE-1:0] pub_qy,
  output logic                pubkey_valid,
  output logic                busy,
  input  logic [TMO_W-1:0]    timeout_cycles
);

  state_e              state;
  fifo_entry_t         cur;
  fifo_entry_t         head_e;
  logic [TAG_W+1:0]    head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                rsp_valid_q;
  status_e             rsp_status_q;
  logic [KEY_SIZE-1:0] rsp_r_q;
  logic [KEY_SIZE-1:0] rsp_s_q;
  logic                tmo_hit;
  logic                unused_tag;

  assign pop = (state == S_IDLE) && !fifo_empty;

  ecdsa_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (TAG_W + 2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.cmd_valid),
    .push_data ({bus.cmd_op, bus.cmd_tag}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_e.op  = op_e'(head[TAG_W+1:TAG_W]);
  assign head_e.tag = TAG_MAX_W'(head[TAG_W-1:0]);
  assign unused_tag = ^cur.tag;

  assign bus.cmd_ready  = !fifo_full;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_op     = cur.op;
  assign bus.rsp_tag    = cur.tag[TAG_W-1:0];
  assign bus.rsp_status = rsp_status_q;
  assign bus.rsp_r      = rsp_r_q;
  assign bus.rsp_s      = rsp_s_q;
  assign busy = (state != S_IDLE) || !fifo_empty;

`ifdef ECDSA_CMD_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = (timeout_cycles != '0) &&
    (({1'b0, tmo_cnt} + (TMO_W+1)'(1)) ==
     {1'b0, timeout_cycles});

  // Watchdog: cleared entering ISSUE, runs in ISSUE/WAIT.
  always_ff @(posedge clk) begin
    if (rst || state == S_CHECK) begin
      tmo_cnt <= '0;
    end else if (state == S_ISSUE || state == S_WAIT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = ^timeout_cycles;
`endif

  // Command sequencer; engine pulses and response are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cur          <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= ST_OK;
      rsp_r_q      <= '0;
      rsp_s_q      <= '0;
      ecc_go       <= 1'b0;
      sign_go      <= 1'b0;
      verify_go    <= 1'b0;
      pubkey_valid <= 1'b0;
      pub_qx       <= '0;
      pub_qy       <= '0;
    end else begin
      ecc_go    <= 1'b0;
      sign_go   <= 1'b0;
      verify_go <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            cur   <= head_e;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          rsp_r_q <= '0;
          rsp_s_q <= '0;
          unique case (1'b1)
            cur.op == OP_CLRKEY: begin
              pubkey_valid <= 1'b0;
              rsp_status_q <= ST_OK;
              rsp_valid_q  <= 1'b1;
              state        <= S_RESP;
            end
            needs_key(cur.op) && !pubkey_valid: begin
              rsp_status_q <= ST_NOKEY;
              rsp_valid_q  <= 1'b1;
              state        <= S_RESP;
            end
            default: begin
              ecc_go <= (cur.op == OP_KEYGEN);
              state  <= S_ISSUE;
            end
          endcase
        end
        S_ISSUE: begin
          if (tmo_hit) begin
            rsp_status_q <= ST_TIMEOUT;
            rsp_valid_q  <= 1'b1;
            state        <= S_RESP;
          end else begin
            unique case (cur.op)
              OP_KEYGEN: state <= S_WAIT;
              OP_SIGN: begin
                if (sign_ready) begin
                  sign_go <= 1'b1;
                  state   <= S_WAIT;
                end
              end
              OP_VERIFY: begin
                if (verify_ready) begin
                  verify_go <= 1'b1;
                  state     <= S_WAIT;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
        S_WAIT: begin
          if (cur.op == OP_KEYGEN && ecc_done) begin
            if (!ecc_infinity) begin
              pub_qx       <= ecc_qx;
              pub_qy       <= ecc_qy;
              pubkey_valid <= 1'b1;
              rsp_status_q <= ST_OK;
            end else begin
              rsp_status_q <= ST_FAIL;
            end
            rsp_valid_q <= 1'b1;
            state       <= S_RESP;
          end else if (cur.op == OP_SIGN && sign_done) begin
            rsp_r_q      <= sign_r;
            rsp_s_q      <= sign_s;
            rsp_status_q <= sign_failure ? ST_FAIL : ST_OK;
            rsp_valid_q  <= 1'b1;
            state        <= S_RESP;
          end else if (cur.op == OP_VERIFY && verify_done) begin
            rsp_status_q <= verify_ok ? ST_OK : ST_FAIL;
            rsp_valid_q  <= 1'b1;
            state        <= S_RESP;
          end else if (tmo_hit) begin
            rsp_status_q <= ST_TIMEOUT;
            rsp_valid_q  <= 1'b1;
            state        <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecdsa_cmd_ctrl.sv
// Directed bench for ecdsa_cmd_ctrl with simple engine models.
// Define ECDSA_CMD_TIMEOUT_EN to also exercise the watchdog.
module tb_ecdsa_cmd_ctrl;
  import ecdsa_ctrl_pkg::*;

  localparam int KS = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ecc_go, sign_go, verify_go;
  logic          ecc_done = 0, ecc_infinity = 0;
  logic [KS-1:0] ecc_qx = KS'(8'h11), ecc_qy = KS'(8'h22);
  logic          sign_ready = 1, sign_done = 0, sign_failure = 0;
  logic [KS-1:0] sign_r = KS'(8'hAA), sign_s = KS'(8'hBB);
  logic          verify_ready = 1, verify_done = 0, verify_ok = 0;
  logic [KS-1:0] pub_qx, pub_qy;
  logic          pubkey_valid, busy;
  logic [15:0]   timeout_cycles = '0;

  int pass = 0;
  int total = 0;

  ecdsa_cmd_ctrl_if #(.KEY_SIZE(KS), .TAG_W(4)) bus ();

  ecdsa_cmd_ctrl #(
    .KEY_SIZE(KS), .DEPTH(4), .TAG_W(4), .TMO_W(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ecc_go(ecc_go), .ecc_done(ecc_done),
    .ecc_infinity(ecc_infinity),
    .ecc_qx(ecc_qx), .ecc_qy(ecc_qy),
    .sign_go(sign_go), .sign_ready(sign_ready),
    .sign_done(sign_done), .sign_failure(sign_failure),
    .sign_r(sign_r), .sign_s(sign_s),
    .verify_go(verify_go), .verify_ready(verify_ready),
    .verify_done(verify_done), .verify_ok(verify_ok),
    .pub_qx(pub_qx), .pub_qy(pub_qy),
    .pubkey_valid(pubkey_valid), .busy(busy),
    .timeout_cycles(timeout_cycles)
  );

  always #5 clk = ~clk;

  // Engine models: done arrives a fixed latency after go.
  int ecc_lat = 10, sign_lat = 10, verify_lat = 4;
  int ecc_cnt = 0, sign_cnt = 0, verify_cnt = 0;
  int sign_go_cnt = 0, go_err = 0;
  bit verify_en = 1, late_verify = 0;
  bit ecc_go_d = 0, sign_go_d = 0, verify_go_d = 0;

  always @(negedge clk) begin
    ecc_done = 0;
    sign_done = 0;
    verify_done = 0;
    if (ecc_cnt > 0) begin
      ecc_cnt--;
      if (ecc_cnt == 0) ecc_done = 1;
    end
    if (sign_cnt > 0) begin
      sign_cnt--;
      if (sign_cnt == 0) sign_done = 1;
    end
    if (verify_cnt > 0) begin
      verify_cnt--;
      if (verify_cnt == 0 && verify_en) verify_done = 1;
    end
    if (late_verify) begin
      verify_done = 1;
      late_verify = 0;
    end
    if (ecc_go) ecc_cnt = ecc_lat;
    if (sign_go) begin
      sign_cnt = sign_lat;
      sign_go_cnt++;
    end
    if (verify_go) verify_cnt = verify_lat;
    if ((ecc_go && ecc_go_d) || (sign_go && sign_go_d) ||
        (verify_go && verify_go_d)) go_err++;
    if (int'(ecc_go) + int'(sign_go) + int'(verify_go) > 1)
      go_err++;
    ecc_go_d = ecc_go;
    sign_go_d = sign_go;
    verify_go_d = verify_go;
  end

  task automatic push(input op_e op, input logic [3:0] tag);
    bit ok = 0;
    @(negedge clk);
    bus.cmd_valid = 1;
    bus.cmd_op = op;
    bus.cmd_tag = tag;
    for (int i = 0; i < 60; i++) begin
      if (bus.cmd_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1 bus.cmd_valid = 0;
    total++;
    if (!ok) $display("FAIL push tag %0d: ready=0 want 1", tag);
    else pass++;
  endtask

  task automatic wait_rsp(input int budget, output bit got,
                          output logic [1:0] op,
                          output logic [3:0] tag,
                          output logic [1:0] st,
                          output logic [KS-1:0] r,
                          output logic [KS-1:0] s);
    got = 0;
    op = 0; tag = 0; st = 0; r = 0; s = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1;
        break;
      end
    end
    if (got) begin
      op = bus.rsp_op;
      tag = bus.rsp_tag;
      st = bus.rsp_status;
      r = bus.rsp_r;
      s = bus.rsp_s;
      bus.rsp_ready = 1;
      @(posedge clk);
      #1 bus.rsp_ready = 0;
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    total++;
    if (bus.cmd_ready !== 1'b1)
      $display("FAIL rst cmd_ready: got %b want 1", bus.cmd_ready);
    else pass++;
    total++;
    if ({bus.rsp_valid, pubkey_valid, busy} !== 3'b000)
      $display("FAIL rst flags: got %b want 000",
               {bus.rsp_valid, pubkey_valid, busy});
    else pass++;
    total++;
    if ({ecc_go, sign_go, verify_go} !== 3'b000)
      $display("FAIL rst go: got %b want 000",
               {ecc_go, sign_go, verify_go});
    else pass++;
    total++;
    if (pub_qx !== '0 || bus.rsp_r !== '0)
      $display("FAIL rst data: qx %0h r %0h want 0",
               pub_qx, bus.rsp_r);
    else pass++;
  endtask

  task automatic test_keygen;
    bit g; logic [1:0] op, st; logic [3:0] tg;
    logic [KS-1:0] r, s;
    push(OP_KEYGEN, 4'd1);
    wait_rsp(60, g, op, tg, st, r, s);
    total++;
    if (!g || st !== ST_OK || tg !== 4'd1 || op !== OP_KEYGEN)
      $display("FAIL keygen rsp: got g%0d st%0d tag%0d want 1 0 1",
               g, st, tg);
    else pass++;
    total++;
    if (pub_qx !== KS'(8'h11) || pub_qy !== KS'(8'h22) ||
        pubkey_valid !== 1'b1)
      $display("FAIL keygen pub: qx %0h v %b want 11 1",
               pub_qx, pubkey_valid);
    else pass++;
  endtask

  task automatic test_keygen_inf;
    bit g; logic [1:0] op, st; logic [3:0] tg;
    logic [KS-1:0] r, s;
    ecc_infinity = 1;
    ecc_qx = KS'(8'h33);
    push(OP_KEYGEN, 4'd5);
    wait_rsp(60, g, op, tg, st, r, s);
    total++;
    if (!g || st !== ST_FAIL || tg !== 4'd5)
      $display("FAIL keygen_inf rsp: got st%0d tag%0d want 1 5",
               st, tg);
    else pass++;
    total++;
    if (pub_qx !== KS'(8'h11) || pubkey_valid !== 1'b1)
      $display("FAIL keygen_inf pub: qx %0h v %b want 11 1",
               pub_qx, pubkey_valid);
    else pass++;
    ecc_infinity = 0;
    ecc_qx = KS'(8'h11);
  endtask

  task automatic test_back_to_back;
    bit g; logic [1:0] op, st; logic [3:0] tg;
    logic [KS-1:0] r, s;
    logic [1:0] e_op [3] = '{OP_KEYGEN, OP_SIGN, OP_VERIFY};
    logic [1:0] e_st [3] = '{ST_OK, ST_OK, ST_FAIL};
    logic [7:0] e_r [3] = '{8'h00, 8'hAA, 8'h00};
    logic [7:0] e_s [3] = '{8'h00, 8'hBB, 8'h00};
    verify_ok = 0;
    push(OP_KEYGEN, 4'd6);
    push(OP_SIGN, 4'd7);
    push(OP_VERIFY, 4'd8);
    for (int i = 0; i < 3; i++) begin
      wait_rsp(100, g, op, tg, st, r, s);
      total++;
      if (!g || op !== e_op[i] || tg !== 4'(6 + i) ||
          st !== e_st[i] || r !== KS'(e_r[i]) ||
          s !== KS'(e_s[i]))
        $display("FAIL b2b[%0d]: g%0d op%0d tag%0d st%0d r%0h s%0h want op%0d tag%0d st%0d r%0h s%0h",
                 i, g, op, tg, st, r[7:0], s[7:0],
                 e_op[i], 6 + i, e_st[i], e_r[i], e_s[i]);
      else pass++;
    end
  endtask

  task automatic test_stall;
    bit g, stable; logic [1:0] op, st; logic [3:0] tg;
    logic [KS-1:0] r, s;
    push(OP_CLRKEY, 4'd3);
    repeat (3) @(negedge clk);
    for (int t = 4; t <= 7; t++) push(OP_CLRKEY, 4'(t));
    @(negedge clk);
    total++;
    if (bus.cmd_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL stall full: ready %b busy %b want 0 1",
               bus.cmd_ready, busy);
    else pass++;
    stable = 1;
    for (int i = 0; i < 6; i++) begin
      if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 4'd3 ||
          bus.rsp_status !== ST_OK || bus.cmd_ready !== 1'b0)
        stable = 0;
      @(negedge clk);
    end
    total++;
    if (!stable)
      $display("FAIL stall hold: rsp moved, got tag %0d want 3",
               bus.rsp_tag);
    else pass++;
    for (int t = 3; t <= 7; t++) begin
      wait_rsp(40, g, op, tg, st, r, s);
      total++;
      if (!g || tg !== 4'(t) || op !== OP_CLRKEY || st !== ST_OK)
        $display("FAIL stall drain: g%0d tag%0d st%0d want tag%0d st0",
                 g, tg, st, t);
      else pass++;
    end
    total++;
    if (pubkey_valid !== 1'b0)
      $display("FAIL clrkey: pubkey_valid %b want 0", pubkey_valid);
    else pass++;
  endtask

  task automatic test_nokey;
    bit g; logic [1:0] op, st; logic [3:0] tg;
    logic [KS-1:0] r, s;
    do_reset();
    sign_go_cnt = 0;
    push(OP_SIGN, 4'd2);
    wait_rsp(40, g, op, tg, st, r, s);
    total++;
    if (!g || st !== ST_NOKEY || tg !== 4'd2)
      $display("FAIL nokey rsp: g%0d st%0d tag%0d want 1 2 2",
               g, st, tg);
    else pass++;
    total++;
    if (sign_go_cnt != 0)
      $display("FAIL nokey go: sign_go count %0d want 0",
               sign_go_cnt);
    else pass++;
  endtask

  task automatic test_rst_mid_wait;
    bit g, seen, spur; logic [1:0] op, st; logic [3:0] tg;
    logic [KS-1:0] r, s;
    push(OP_KEYGEN, 4'd4);
    wait_rsp(60, g, op, tg, st, r, s);
    push(OP_SIGN, 4'd9);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sign_go) begin
        seen = 1;
        break;
      end
    end
    total++;
    if (!seen) $display("FAIL midwait go: sign_go 0 want 1");
    else pass++;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    spur = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) spur = 1;
    end
    total++;
    if (spur || pubkey_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL midwait abort: rsp %b key %b busy %b want 000",
               spur, pubkey_valid, busy);
    else pass++;
    push(OP_KEYGEN, 4'd10);
    wait_rsp(60, g, op, tg, st, r, s);
    total++;
    if (!g || st !== ST_OK || tg !== 4'd10 || pubkey_valid !== 1)
      $display("FAIL midwait keygen: g%0d st%0d tag%0d want 1 0 10",
               g, st, tg);
    else pass++;
  endtask

`ifdef ECDSA_CMD_TIMEOUT_EN
  task automatic test_timeout;
    bit g, seen, spur; logic [1:0] op, st; logic [3:0] tg;
    logic [KS-1:0] r, s;
    int n;
    verify_en = 0;
    timeout_cycles = 16'd20;
    push(OP_VERIFY, 4'd11);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (verify_go) begin
        seen = 1;
        break;
      end
    end
    n = 0;
    for (int i = 0; i < 40 && seen; i++) begin
      @(negedge clk);
      n++;
      if (bus.rsp_valid) break;
    end
    total++;
    if (!seen || n != 19)
      $display("FAIL tmo timing: go %0d cycles %0d want 1 19",
               seen, n);
    else pass++;
    wait_rsp(5, g, op, tg, st, r, s);
    total++;
    if (!g || st !== ST_TIMEOUT || tg !== 4'd11)
      $display("FAIL tmo rsp: g%0d st%0d tag%0d want 1 3 11",
               g, st, tg);
    else pass++;
    late_verify = 1;
    spur = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rsp_valid || busy) spur = 1;
    end
    total++;
    if (spur) $display("FAIL tmo late done: rsp 1 want 0");
    else pass++;
    verify_en = 1;
    timeout_cycles = '0;
  endtask
`endif

  initial begin
    bus.cmd_valid = 0;
    bus.cmd_op = OP_KEYGEN;
    bus.cmd_tag = '0;
    bus.rsp_ready = 0;
    test_reset();
    test_keygen();
    test_keygen_inf();
    test_back_to_back();
    test_stall();
    test_nokey();
    test_rst_mid_wait();
`ifdef ECDSA_CMD_TIMEOUT_EN
    test_timeout();
`endif
    total++;
    if (go_err != 0)
      $display("FAIL go pulses: %0d bad pulses want 0", go_err);
    else pass++;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
